// File: rtl/gal_olmc_acw_sequencer.sv
// gal_olmc_acw_sequencer
// Holds the per-OLMC architecture configuration {REGISTERED, INVERTED, OE}
// and shifts it into the GAL architecture-control-word chain, then issues a
// program strobe.
//
// Ports:
//   C          clock, all logic on rising edge
//   R          synchronous active-high reset
//   cfg_wr     write shadow entry cfg_idx with cfg_data (accepted in IDLE only)
//   cfg_idx    target OLMC index (IDX_W may be widened beyond $clog2(N_OLMC))
//   cfg_data   {REGISTERED, INVERTED, OE}
//   cfg_ready  high in IDLE: writes and start are accepted
//   start      begin a program sequence
//   busy       high in LOAD, SHIFT, PULSE
//   done       one-cycle pulse when the sequence completes
//   err        sticky: out-of-range write attempted; cleared by start
//   sdo        serial data to device, stable for a whole bit period
//   sclk       serial clock to device; device samples on its rising edge
//   strobe     program strobe, high PROG_PULSE cycles
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | accept shadow writes and start
// LOAD  | capture shadow into shift register, present first bit
// SHIFT | clock out 3*N_OLMC bits, CLK_DIV low then CLK_DIV high per bit
// PULSE | hold strobe for PROG_PULSE cycles
// DONE  | single-cycle done pulse, back to IDLE
//
// N_OLMC must be >= 2, CLK_DIV >= 1, PROG_PULSE >= 1.

module gal_olmc_acw_sequencer #(
  parameter int N_OLMC     = 8,
  parameter int CLK_DIV    = 2,
  parameter int PROG_PULSE = 4,
  parameter int IDX_W      = $clog2(N_OLMC)
) (
  input  logic             C,
  input  logic             R,
  input  logic             cfg_wr,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [2:0]       cfg_data,
  output logic             cfg_ready,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             sdo,
  output logic             sclk,
  output logic             strobe
);

  localparam int NBITS = 3 * N_OLMC;
  localparam int BCW   = $clog2(NBITS + 1);
  localparam int PHW   = $clog2(2 * CLK_DIV);
  localparam int PCW   = $clog2(PROG_PULSE + 1);
  localparam int SIW   = $clog2(N_OLMC);

  localparam logic [PHW-1:0] PH_TOP = PHW'(2 * CLK_DIV - 1);
  localparam logic [PHW-1:0] PH_HI  = PHW'(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_PULSE,
    S_DONE
  } state_t;

  state_t           state;
  logic [2:0]       shadow [N_OLMC];
  logic [NBITS-1:0] sreg;
  logic [BCW-1:0]   bit_cnt;
  logic [PHW-1:0]   phase_cnt;
  logic [PCW-1:0]   pulse_cnt;
  logic             idx_ok;

  assign idx_ok    = {{(32-IDX_W){1'b0}}, cfg_idx} < 32'(N_OLMC);
  assign cfg_ready = (state == S_IDLE);
  assign busy      = (state == S_LOAD) || (state == S_SHIFT) || (state == S_PULSE);
  assign done      = (state == S_DONE);

  always_ff @(posedge C) begin
    if (R) begin
      state     <= S_IDLE;
      for (int i = 0; i < N_OLMC; i++) shadow[i] <= 3'b001;
      sreg      <= '0;
      bit_cnt   <= '0;
      phase_cnt <= '0;
      pulse_cnt <= '0;
      sdo       <= 1'b0;
      sclk      <= 1'b0;
      strobe    <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            err   <= 1'b0;
            state <= S_LOAD;
          end
          // placed after the start clear so a same-cycle bad write keeps err set
          if (cfg_wr) begin
            if (idx_ok) shadow[cfg_idx[SIW-1:0]] <= cfg_data;
            else        err <= 1'b1;
          end
        end

        S_LOAD: begin
          // highest OLMC lands in the MSBs so it leaves first
          for (int i = 0; i < N_OLMC; i++) sreg[3*i +: 3] <= shadow[i];
          sdo       <= shadow[N_OLMC-1][2];
          sclk      <= 1'b0;
          bit_cnt   <= BCW'(NBITS);
          phase_cnt <= PH_TOP;
          state     <= S_SHIFT;
        end

        S_SHIFT: begin
          if (phase_cnt == '0) begin
            sclk <= 1'b0;
            if (bit_cnt == BCW'(1)) begin
              sdo       <= 1'b0;
              strobe    <= 1'b1;
              bit_cnt   <= '0;
              pulse_cnt <= PCW'(PROG_PULSE);
              state     <= S_PULSE;
            end else begin
              sreg      <= {sreg[NBITS-2:0], 1'b0};
              sdo       <= sreg[NBITS-2];
              bit_cnt   <= bit_cnt - 1'b1;
              phase_cnt <= PH_TOP;
            end
          end else begin
            // high phase covers phase_cnt values CLK_DIV-1 .. 0
            phase_cnt <= phase_cnt - 1'b1;
            sclk      <= (phase_cnt <= PH_HI);
          end
        end

        S_PULSE: begin
          if (pulse_cnt == PCW'(1)) begin
            strobe    <= 1'b0;
            pulse_cnt <= '0;
            state     <= S_DONE;
          end else begin
            pulse_cnt <= pulse_cnt - 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gal_olmc_acw_sequencer.sv
// Self-checking bench for gal_olmc_acw_sequencer: a shadow-array model
// predicts the serial stream, err, and sequence timing; directed cases are
// followed by randomized write/start rounds.

module tb_gal_olmc_acw_sequencer;

  localparam int N   = 8;
  localparam int CD  = 2;
  localparam int PP  = 4;
  localparam int IW  = 4;
  localparam int NB  = 3 * N;
  localparam int LAT = 1 + 6 * N * CD + PP;

  logic          C = 1'b0;
  logic          R = 1'b1;
  logic          cfg_wr = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [2:0]    cfg_data = '0;
  logic          start = 1'b0;
  logic          cfg_ready, busy, done, err, sdo, sclk, strobe;

  int n_chk = 0;
  int n_err = 0;

  logic [2:0] m_shadow [N];
  bit         m_err;

  gal_olmc_acw_sequencer #(
    .N_OLMC(N), .CLK_DIV(CD), .PROG_PULSE(PP), .IDX_W(IW)
  ) dut (
    .C(C), .R(R), .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .start(start), .busy(busy), .done(done),
    .err(err), .sdo(sdo), .sclk(sclk), .strobe(strobe)
  );

  always #5 C = ~C;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge C);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < N; i++) m_shadow[i] = 3'b001;
    m_err = 1'b0;
  endtask

  function automatic logic [63:0] expected_stream();
    logic [63:0] s = '0;
    for (int i = N - 1; i >= 0; i--)
      for (int b = 2; b >= 0; b--)
        s = {s[62:0], m_shadow[i][b]};
    return s;
  endfunction

  task automatic wr(input int idx, input logic [2:0] data);
    check("ready_before_wr", cfg_ready, 1);
    cfg_wr = 1'b1; cfg_idx = IW'(idx); cfg_data = data;
    step;
    cfg_wr = 1'b0;
    if (idx < N) m_shadow[idx] = data;
    else         m_err = 1'b1;
    check("err_after_wr", err, m_err);
  endtask

  // Runs one sequence from the current IDLE cycle. Optional write on the
  // start cycle, optional interference mid-shift, optional reset after
  // rst_bit sampled bits. Ends in the IDLE cycle after done.
  task automatic run_seq(input bit sw, input int sidx, input logic [2:0] sdat,
                         input bit meddle, input int rst_bit);
    logic [63:0] got, s_exp;
    int nbits, nstb, done_at, bad_busy, bad_ready, bad_sclk, quiet;
    bit prev, rose;
    got = '0; nbits = 0; nstb = 0; done_at = -1;
    bad_busy = 0; bad_ready = 0; bad_sclk = 0; prev = 1'b0;

    check("ready_at_start", cfg_ready, 1);
    cfg_wr = sw; cfg_idx = IW'(sidx); cfg_data = sdat; start = 1'b1;
    if (sw && sidx < N) m_shadow[sidx] = sdat;
    m_err = sw && (sidx >= N);
    s_exp = expected_stream();
    step;
    cfg_wr = 1'b0; start = 1'b0;

    for (int k = 0; k <= LAT + 20 && done_at < 0; k++) begin
      if (done) begin
        done_at = k;
        check("busy_at_done", busy, 0);
      end else begin
        if (!busy) bad_busy++;
        if (cfg_ready) bad_ready++;
      end
      rose = sclk && !prev;
      if (rose) begin
        nbits++;
        got = {got[62:0], sdo};
      end
      if (strobe) begin
        nstb++;
        if (sclk) bad_sclk++;
      end
      prev = sclk;

      if (rst_bit > 0 && rose && nbits == rst_bit) begin
        R = 1'b1;
        step;
        R = 1'b0;
        model_reset();
        check("abort_sclk", sclk, 0);
        check("abort_sdo", sdo, 0);
        check("abort_strobe", strobe, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", cfg_ready, 1);
        check("abort_err", err, 0);
        quiet = 0;
        for (int q = 0; q < 150; q++) begin
          if (strobe || done || sclk) quiet++;
          step;
        end
        check("abort_quiet", quiet, 0);
        return;
      end

      if (meddle && k == 40) begin
        cfg_wr = 1'b1; cfg_idx = IW'(2); cfg_data = 3'b111; start = 1'b1;
        step;
        cfg_wr = 1'b0; start = 1'b0;
      end else begin
        step;
      end
    end

    check("done_latency", done_at, LAT);
    check("sclk_rises", nbits, NB);
    check("stream", got, s_exp);
    check("strobe_len", nstb, PP);
    check("busy_gaps", bad_busy, 0);
    check("ready_while_busy", bad_ready, 0);
    check("sclk_in_pulse", bad_sclk, 0);
    check("err_in_seq", err, m_err);
    check("done_one_cycle", done, 0);
    check("ready_after", cfg_ready, 1);
  endtask

  initial begin
    model_reset();
    R = 1'b1;
    step;
    step;
    R = 1'b0;
    check("rst_sdo", sdo, 0);
    check("rst_sclk", sclk, 0);
    check("rst_strobe", strobe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ready", cfg_ready, 1);

    // defaults
    run_seq(0, 0, 3'b000, 0, 0);

    // end entries, then back-to-back reshift of the same data
    wr(7, 3'b110);
    wr(0, 3'b011);
    run_seq(0, 0, 3'b000, 0, 0);
    run_seq(0, 0, 3'b000, 0, 0);

    // write on the start cycle wins before capture
    run_seq(1, 3, 3'b100, 0, 0);

    // write/start during SHIFT ignored
    run_seq(0, 0, 3'b000, 1, 0);
    run_seq(0, 0, 3'b000, 0, 0);

    // out-of-range write: sticky err, cleared by start
    wr(9, 3'b111);
    step;
    check("err_sticky", err, 1);
    run_seq(0, 0, 3'b000, 0, 0);
    // out-of-range write on the start cycle keeps err set
    run_seq(1, 12, 3'b010, 0, 0);
    run_seq(0, 0, 3'b000, 0, 0);

    // reset mid-shift, then confirm shadow is back to defaults
    run_seq(0, 0, 3'b000, 0, 10);
    run_seq(0, 0, 3'b000, 0, 0);

    // randomized rounds
    for (int r = 0; r < 8; r++) begin
      int nw;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++) begin
        wr($urandom_range(0, 11), 3'($urandom));
        if ($urandom_range(0, 1) == 1) step;
      end
      run_seq($urandom_range(0, 1), $urandom_range(0, 10), 3'($urandom),
              $urandom_range(0, 3) == 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
